// File: rtl/morse_keyer_ctrl.sv
// Morse keyer: serialises one letter (length + dot/dash pattern) onto key_out
// using whole time units, with valid/ready intake and a synchronous abort.
module morse_keyer_ctrl #(
   parameter int unsigned UNIT_CYCLES = 2,
   parameter int unsigned MAX_SYM     = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sym_valid,
   output logic               sym_ready,
   input  logic [2:0]         sym_len,
   input  logic [MAX_SYM-1:0] sym_pat,
   input  logic               abort,
   output logic               key_out,
   output logic               busy,
   output logic               done
);

   localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MARK,
      S_GAP,
      S_LGAP,
      S_WGAP
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      pre_q, pre_d;
   logic [2:0]         unit_q, unit_d;
   logic [2:0]         idx_q, idx_d;
   logic [MAX_SYM-1:0] pat_q, pat_d;
   logic               key_q, busy_q, done_q, done_d;
   logic               init_q;

   logic               unit_tick;
   logic               last_unit;
   logic [2:0]         target_units;
   logic [2:0]         len_eff;

   assign unit_tick = (pre_q == PW'(UNIT_CYCLES - 1));
   assign len_eff   = (sym_len > 3'(MAX_SYM)) ? 3'(MAX_SYM) : sym_len;

   // Length of the current state in Morse units.
   always_comb begin
      target_units = 3'd1;
      case (state_q)
         S_MARK:  target_units = pat_q[idx_q] ? 3'd3 : 3'd1;
         S_GAP:   target_units = 3'd1;
         S_LGAP:  target_units = 3'd3;
         S_WGAP:  target_units = 3'd7;
         default: target_units = 3'd1;
      endcase
   end

   assign last_unit = unit_tick && (unit_q == target_units - 3'd1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      done_d  = 1'b0;
      pre_d   = unit_tick ? '0 : pre_q + PW'(1);
      unit_d  = unit_tick ? unit_q + 3'd1 : unit_q;

      case (state_q)
         S_IDLE: begin
            if (sym_valid && sym_ready) begin
               pat_d = sym_pat;
               if (len_eff == 3'd0) begin
                  state_d = S_WGAP;
               end else begin
                  state_d = S_MARK;
                  idx_d   = len_eff - 3'd1;
               end
            end
         end
         S_MARK: begin
            if (last_unit) begin
               if (idx_q != 3'd0) begin
                  state_d = S_GAP;
                  idx_d   = idx_q - 3'd1;
               end else begin
                  state_d = S_LGAP;
               end
            end
         end
         S_GAP: begin
            if (last_unit) state_d = S_MARK;
         end
         S_LGAP, S_WGAP: begin
            if (last_unit) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Cancel wins over any normal transition and suppresses the done pulse.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end

      if ((state_d != state_q) || (state_d == S_IDLE)) begin
         pre_d  = '0;
         unit_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         unit_q  <= '0;
         idx_q   <= '0;
         pat_q   <= '0;
         key_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         unit_q  <= unit_d;
         idx_q   <= idx_d;
         pat_q   <= pat_d;
         key_q   <= (state_d == S_MARK);
         busy_q  <= (state_d != S_IDLE);
         done_q  <= done_d;
         init_q  <= 1'b1;
      end
   end

   // init_q keeps sym_ready low until the first edge after reset release.
   assign sym_ready = init_q && (state_q == S_IDLE);
   assign key_out   = key_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Randomised bench for morse_keyer_ctrl: each letter is expanded into its
// expected per-cycle key waveform from the unit-timing rules and compared.
module tb_morse_keyer_ctrl;

   localparam int UC = 2;
   localparam int MS = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sym_valid = 1'b0;
   logic          sym_ready;
   logic [2:0]    sym_len = 3'd0;
   logic [MS-1:0] sym_pat = '0;
   logic          abort = 1'b0;
   logic          key_out;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   morse_keyer_ctrl #(.UNIT_CYCLES(UC), .MAX_SYM(MS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_len   (sym_len),
      .sym_pat   (sym_pat),
      .abort     (abort),
      .key_out   (key_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic exp_done);
      check_val({tag, "_key"},   32'(key_out),   32'd0);
      check_val({tag, "_busy"},  32'(busy),      32'd0);
      check_val({tag, "_ready"}, 32'(sym_ready), 32'd1);
      check_val({tag, "_done"},  32'(done),      32'(exp_done));
   endtask

   // Called at a sample point with sym_ready expected high; returns at the
   // done cycle (or the cycle after an abort), again with sym_ready high.
   task automatic send(input int len, input logic [MS-1:0] pat, input int abort_at, input bit pulse);
      bit q[$];
      int le;
      int t_len;
      le = (len > MS) ? MS : len;
      if (le == 0) begin
         repeat (7 * UC) q.push_back(1'b0);
      end else begin
         for (int i = le - 1; i >= 0; i--) begin
            repeat ((pat[i] ? 3 : 1) * UC) q.push_back(1'b1);
            repeat ((i > 0 ? 1 : 3) * UC) q.push_back(1'b0);
         end
      end
      t_len = q.size();
      $display("letter len=%0d pat=%b cycles=%0d abort_at=%0d pulse=%0d",
               len, pat, t_len, abort_at, pulse);
      sym_valid = 1'b1;
      sym_len   = 3'(len);
      sym_pat   = pat;
      for (int k = 1; k <= t_len; k++) begin
         next_cycle();
         sym_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
         if (pulse) begin
            sym_len = 3'($urandom_range(0, 7));
            sym_pat = MS'($urandom);
         end
         check_val("key",   32'(key_out),   32'(q[k-1]));
         check_val("busy",  32'(busy),      32'd1);
         check_val("done",  32'(done),      32'd0);
         check_val("ready", 32'(sym_ready), 32'd0);
         if (k == abort_at) begin
            abort = 1'b1;
            next_cycle();
            abort = 1'b0;
            sym_valid = 1'b0;
            check_idle("abort", 1'b0);
            return;
         end
      end
      sym_valid = 1'b0;
      next_cycle();
      check_idle("complete", 1'b1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         check_idle("idle", 1'b0);
      end
   endtask

   initial begin
      // Reset values while held in reset.
      #2;
      check_val("rst_key",   32'(key_out),   32'd0);
      check_val("rst_busy",  32'(busy),      32'd0);
      check_val("rst_done",  32'(done),      32'd0);
      check_val("rst_ready", 32'(sym_ready), 32'd0);
      #10 rst_n = 1'b1;
      #1 check_val("rst_ready_pre_edge", 32'(sym_ready), 32'd0);
      next_cycle();
      check_idle("post_reset", 1'b0);

      // Directed: B, word space, E/T back-to-back, abort on O, clamp with pulses.
      send(4, 5'b01000, 0, 1'b0);
      idle_cycles(1);
      send(0, 5'b00000, 0, 1'b0);
      idle_cycles(2);
      send(1, 5'b00000, 0, 1'b0);
      send(1, 5'b00001, 0, 1'b0);
      idle_cycles(1);
      send(3, 5'b00111, 4, 1'b0);
      idle_cycles(3);
      send(7, 5'b10101, 0, 1'b1);
      idle_cycles(1);

      // Abort while idle is ignored.
      abort = 1'b1;
      next_cycle();
      abort = 1'b0;
      check_idle("abort_idle", 1'b0);

      // Asynchronous reset in the middle of a dash.
      sym_valid = 1'b1;
      sym_len   = 3'd1;
      sym_pat   = 5'b00001;
      next_cycle();
      sym_valid = 1'b0;
      next_cycle();
      check_val("middash_key", 32'(key_out), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check_val("arst_key",   32'(key_out),   32'd0);
      check_val("arst_busy",  32'(busy),      32'd0);
      check_val("arst_ready", 32'(sym_ready), 32'd0);
      check_val("arst_done",  32'(done),      32'd0);
      #2 rst_n = 1'b1;
      #1 check_val("arst_ready_pre_edge", 32'(sym_ready), 32'd0);
      next_cycle();
      check_idle("arst_release", 1'b0);

      // Randomised traffic.
      for (int n = 0; n < 150; n++) begin
         int len;
         int ab;
         logic [MS-1:0] pat;
         len = $urandom_range(0, 7);
         pat = MS'($urandom);
         ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : 0;
         send(len, pat, ab, 1'($urandom_range(0, 1)));
         if (ab != 0 || $urandom_range(0, 1) == 1)
            idle_cycles($urandom_range(1, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
